// File: rtl/cube_scan_driver_pkg.sv
// Shared constants, FSM encoding and LED polarity helpers for the cube scan driver.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cube_scan_driver_pkg;

    localparam int N_PLANES = 3;
    localparam int N_ROWS   = 9;
    localparam int FRAME_W  = 27;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    // Plane sinks are active low, row drives active high.
    localparam logic [N_PLANES-1:0] VERT_DARK = 3'b111;
    localparam logic [N_PLANES-1:0] VERT_LAMP = 3'b000;
    localparam logic [N_ROWS-1:0]   ROWS_DARK = 9'h000;
    localparam logic [N_ROWS-1:0]   ROWS_LAMP = 9'h1FF;

    // Active-low sink pattern selecting a single plane.
    function automatic logic [N_PLANES-1:0] plane_sink(input logic [1:0] p);
        plane_sink = ~(N_PLANES'(1) << p);
    endfunction

    // Nine row bits belonging to plane p of a frame.
    function automatic logic [N_ROWS-1:0] plane_rows(input logic [FRAME_W-1:0] f,
                                                     input logic [1:0]         p);
        case (p)
            2'd0:    plane_rows = f[8:0];
            2'd1:    plane_rows = f[17:9];
            2'd2:    plane_rows = f[26:18];
            default: plane_rows = ROWS_DARK;
        endcase
    endfunction

endpackage

// File: rtl/cube_scan_driver_timer.sv
// Load/terminal-count down-counter timing each blank and dwell interval.
// Latency: done_o is high on the last cycle of a loaded interval of N cycles.
// Backpressure: none; clear_i wins over load_i, the count saturates at zero.
module scan_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;

    // Count down from the loaded interval length; never wraps below zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/cube_scan_driver.sv
// Time-multiplexes a 27-bit LED cube frame onto 3 plane sinks and 9 row drives.
// Latency: outputs registered, reflecting the FSM state entered on the same edge.
// Backpressure: frame_ready low while a shadow frame waits for the next frame boundary.
module cube_scan_driver
    import cube_scan_driver_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                lamp_test,
    input  logic [FRAME_W-1:0]  frame_data,
    input  logic                frame_valid,
    output logic                frame_ready,
    output logic [N_PLANES-1:0] vert_n,
    output logic [N_ROWS-1:0]   rows,
    output logic [1:0]          scan_plane,
    output logic                frame_done
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES);

    state_t               state_q, state_d;
    logic [1:0]           plane_q, plane_d;
    logic [FRAME_W-1:0]   disp_q, disp_d;
    logic [FRAME_W-1:0]   shadow_q;
    logic                 pending_q;
    logic [N_PLANES-1:0]  vert_n_q;
    logic [N_ROWS-1:0]    rows_q;
    logic [1:0]           scan_plane_q;
    logic                 frame_done_q;

    logic                 tmr_done, tmr_load, tmr_clear;
    logic [CNT_W-1:0]     tmr_val;
    logic                 frame_end, accept, swap;

    scan_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_i    (tmr_clear),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // Next-state, plane advance and timer reload on every interval boundary.
    always_comb begin
        state_d   = state_q;
        plane_d   = plane_q;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;
        tmr_val   = DWELL_LD;
        frame_end = 1'b0;
        if (!enable) begin
            state_d   = S_OFF;
            plane_d   = 2'd0;
            tmr_clear = 1'b1;
        end else begin
            case (state_q)
                S_OFF: begin
                    tmr_load = 1'b1;
                    if (BLANK_CYCLES == 0) begin
                        state_d = S_DRIVE;
                    end else begin
                        state_d = S_BLANK;
                        tmr_val = BLANK_LD;
                    end
                end
                S_BLANK: begin
                    if (tmr_done) begin
                        state_d  = S_DRIVE;
                        tmr_load = 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (tmr_done) begin
                        tmr_load  = 1'b1;
                        frame_end = (plane_q == 2'd2);
                        plane_d   = frame_end ? 2'd0 : plane_q + 2'd1;
                        if (BLANK_CYCLES == 0) begin
                            state_d = S_DRIVE;
                        end else begin
                            state_d = S_BLANK;
                            tmr_val = BLANK_LD;
                        end
                    end
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    // A frame is taken only into an empty shadow; a waiting shadow swaps in at frame end.
    assign accept = frame_valid && !pending_q;
    assign swap   = frame_end && pending_q;
    assign disp_d = swap ? shadow_q : disp_q;

    // FSM state and registered LED drive; lamp test overrides only the pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_OFF;
            plane_q      <= 2'd0;
            vert_n_q     <= VERT_DARK;
            rows_q       <= ROWS_DARK;
            scan_plane_q <= 2'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            plane_q      <= plane_d;
            scan_plane_q <= plane_d;
            frame_done_q <= frame_end;
            if (lamp_test) begin
                vert_n_q <= VERT_LAMP;
                rows_q   <= ROWS_LAMP;
            end else if (state_d == S_DRIVE) begin
                vert_n_q <= plane_sink(plane_d);
                rows_q   <= plane_rows(disp_d, plane_d);
            end else begin
                vert_n_q <= VERT_DARK;
                rows_q   <= ROWS_DARK;
            end
        end
    end

    // Shadow capture, pending flag and tear-free displayed frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q  <= '0;
            pending_q <= 1'b0;
            disp_q    <= '0;
        end else begin
            disp_q <= disp_d;
            if (swap) begin
                pending_q <= 1'b0;
            end else if (accept) begin
                shadow_q  <= frame_data;
                pending_q <= 1'b1;
            end
        end
    end

    assign frame_ready = ~pending_q;
    assign vert_n      = vert_n_q;
    assign rows        = rows_q;
    assign scan_plane  = scan_plane_q;
    assign frame_done  = frame_done_q;

endmodule

// File: doc/cube_scan_driver.md
Name: cube_scan_driver

Overview:
- Downstream of the pattern sequencer. Takes a 27-bit cube frame (one bit per LED) and time-multiplexes it onto the 3 vertical plane sinks and 9 row drives, one plane at a time, with a blanking gap between planes to prevent ghosting.
- Frames arrive over a valid/ready handshake into a shadow register. The shadow is swapped into the displayed frame only at frame boundaries, so a frame never tears.

Parameters:
- DWELL_CYCLES, 50000, clk cycles each plane is driven (1 ms at 50 MHz); legal range >= 1.
- BLANK_CYCLES, 8, clk cycles with all planes off between planes; 0 means no blank.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  scanning enabled when high.
- lamp_test  in  1  forces every LED on while high.
- frame_data  in  27  LED bit index = plane*9 + layer*3 + row. Layer 0=bot, 1=mid, 2=top; row 0..2 = R1..R3.
- frame_valid  in  1  frame_data is offered.
- frame_ready  out  1  shadow register is empty and can accept a frame.
- vert_n  out  3  plane sinks, active low; bit p drives plane p.
- rows  out  9  row drives, active high; bit layer*3+row. [2:0]=bot R1..R3, [5:3]=mid, [8:6]=top.
- scan_plane  out  2  plane currently driven (0..2).
- frame_done  out  1  one-cycle pulse at the end of plane 2's dwell.

Behaviour:
- All outputs are registered.
- Reset values: vert_n=3'b111, rows=0, frame_ready=1, frame_done=0, scan_plane=0. Displayed frame, shadow register and pending flag all clear; FSM is in S_OFF.
- States and transitions:
  - S_OFF: outputs dark (vert_n=111, rows=0); counters held at 0. Goes to S_BLANK when enable=1.
  - S_BLANK: outputs dark for exactly BLANK_CYCLES cycles, then S_DRIVE. When BLANK_CYCLES=0, the FSM goes directly to S_DRIVE.
  - S_DRIVE: for exactly DWELL_CYCLES cycles, vert_n = ~(3'b001 << p) and rows = displayed[p*9 +: 9].
    - At the end of the dwell, if p<2: p increments and the FSM goes to S_BLANK.
    - If p==2: p wraps to 0, frame_done pulses for one cycle, the frame swap is applied, and the FSM goes to S_BLANK.
- enable falling: return to S_OFF on the next edge, from any state. Outputs go dark, p resets to 0, and the dwell/blank counter is cleared. Shadow and pending state are kept.
- Handshake:
  - A frame transfers when frame_valid && frame_ready at an edge. The shadow captures frame_data and pending is set.
  - frame_ready = ~pending.
  - frame_valid may be held high indefinitely; extra frames are not accepted while pending=1.
- Swap: at the p==2 dwell end, if pending was 1 before the edge, the displayed frame takes the shadow value and pending clears; frame_ready reads 1 on the following cycle. If pending was 0, the displayed frame is unchanged.
  - Simultaneous accept and swap (pending=0, valid=1 on the swap edge): the frame goes into the shadow, no swap occurs that edge, and the frame is displayed after the next frame boundary.
- First frame after reset: the displayed frame is all-zero until the first swap.
- lamp_test=1 takes priority over everything:
  - Next-edge outputs are vert_n=000 and rows=9'h1FF.
  - The FSM, counters and handshake continue running underneath.
  - When lamp_test drops, outputs return to the FSM-driven values on the next edge.
- Counter width is clog2(max(DWELL_CYCLES, BLANK_CYCLES)+1). The counter never wraps; it clears on every state change.
- Reset asserted mid-scan: all registers return to reset values immediately (asynchronous); any pending frame is lost.

Decomposition:
- Shared package holds:
  - constants N_PLANES=3, N_ROWS=9, FRAME_W=27;
  - state encoding S_OFF/S_BLANK/S_DRIVE (2 bits);
  - plane-sink and row polarity constants.
- One sub-module, scan_timer: a load/terminal-count down-counter. It is loaded with DWELL_CYCLES or BLANK_CYCLES on each state entry and raises a done flag on the last cycle. It is instantiated once.

Test Plan:
All scenarios use DWELL_CYCLES=4 and BLANK_CYCLES=2 unless stated.
1. Reset, then enable=1 with no frame offered -> vert_n cycles 111,111,110 x4,111 x2,101 x4,111 x2,011 x4; rows=0 throughout; frame_done pulses once, on the cycle after the last 011.
2. Offer frame_data=27'h7FC01FF (plane0 all on, plane1 off, plane2 all on) -> accepted in one cycle and frame_ready drops. After the next frame_done, plane0 dwell shows rows=1FF, plane1 shows 000, plane2 shows 1FF, and frame_ready returns to 1.
3. Hold frame_valid=1 with A=27'h0000001, then present B=27'h0000002 while pending -> B is not accepted until after the swap. A is displayed (plane0 rows=001) for a full frame before B (rows=002).
4. Assert lamp_test mid-dwell on plane1 -> next edge gives vert_n=000, rows=1FF. Release after 5 cycles -> outputs resume the FSM values; scan_plane has advanced as if undisturbed.
5. Drop enable during plane2 dwell -> next edge gives vert_n=111, rows=0, scan_plane=0. Re-enable -> the scan restarts with blank then plane0, and the pending frame is preserved.
6. Assert reset_n=0 mid-dwell, asynchronously between edges -> outputs go to reset values without waiting for a clock edge, and frame_ready=1. A rebuild with BLANK_CYCLES=0 must show no 111 gaps between planes.
